// File: rtl/modexp_scheduler_pkg.sv
// Shared definitions for the modular-exponentiation job scheduler:
// FSM encoding, operand/result widths and the default engine timeout.
package modexp_scheduler_pkg;

    localparam int OP_W            = 32;
    localparam int RES_W           = 64;
    localparam int DEFAULT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Width of a requester index; never below one bit so a single requester still works
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modexp_scheduler_if.sv
// Requester-side bus of the scheduler: request/operand inputs, grant and response outputs.
// The master side belongs to the requesters, the slave side to the scheduler.
interface modexp_scheduler_if #(parameter int NREQ = 4);
    import modexp_scheduler_pkg::*;

    localparam int ID_W = id_width(NREQ);

    logic [NREQ-1:0]      req;
    logic [NREQ*OP_W-1:0] req_base;
    logic [NREQ*OP_W-1:0] req_exp;
    logic [NREQ-1:0]      gnt;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [RES_W-1:0]     rsp_data;
    logic                 rsp_err;

    modport master (
        output req, req_base, req_exp,
        input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req, req_base, req_exp,
        output gnt, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/modexp_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_id (wrapping) wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_id,
    output logic [NREQ-1:0] pick_oh,
    output logic [ID_W-1:0] pick_id,
    output logic            any_req
);

    logic [ID_W-1:0] idx;

    // Walk the requesters from last_id+1 around to last_id and keep the first active one
    always_comb begin
        pick_oh = '0;
        pick_id = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = ID_W'((int'(last_id) + i) % NREQ);
            if (!any_req && req[idx]) begin
                any_req      = 1'b1;
                pick_oh[idx] = 1'b1;
                pick_id      = idx;
            end
        end
    end

endmodule

// File: rtl/modexp_scheduler.sv
// Shares one exponentiation engine among NREQ requesters: round-robin grant, operand
// capture, engine start, completion or timeout, then a single response pulse.
module modexp_scheduler
    import modexp_scheduler_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST,
    modexp_scheduler_if.slave bus,
    output logic             busy,
    output logic             eng_start,
    output logic [OP_W-1:0]  eng_base,
    output logic [OP_W-1:0]  eng_exp,
    input  logic [RES_W-1:0] eng_result,
    input  logic             eng_done
);

    localparam int ID_W  = id_width(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [OP_W-1:0]    base_q, base_d;
    logic [OP_W-1:0]    exp_q, exp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               eng_start_q, eng_start_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic [NREQ-1:0]    pick_oh;
    logic [ID_W-1:0]    pick_id;
    logic               any_req;
    logic               cnt_expired;
    logic [OP_W-1:0]    base_slices [NREQ];
    logic [OP_W-1:0]    exp_slices  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign base_slices[g] = bus.req_base[g*OP_W +: OP_W];
        assign exp_slices[g]  = bus.req_exp[g*OP_W +: OP_W];
    end

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req     (bus.req),
        .last_id (last_id_q),
        .pick_oh (pick_oh),
        .pick_id (pick_id),
        .any_req (any_req)
    );

    assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State and datapath registers; reset leaves requester 0 with first priority
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            cur_id_q    <= '0;
            last_id_q   <= ID_W'(NREQ - 1);
            base_q      <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            eng_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            last_id_q   <= last_id_d;
            base_q      <= base_d;
            exp_q       <= exp_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            eng_start_q <= eng_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Next-state logic; engine completion outranks timeout expiry in WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (eng_done || cnt_expired) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath updates; pulses default low, response fields hold their last value
    always_comb begin
        cur_id_d    = cur_id_q;
        last_id_d   = last_id_q;
        base_d      = base_q;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        eng_start_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d    = pick_oh;
                    cur_id_d = pick_id;
                    base_d   = base_slices[pick_id];
                    exp_d    = exp_slices[pick_id];
                end
            end
            ST_ISSUE: begin
                eng_start_d = 1'b1;
                cnt_d       = '0;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = eng_result;
                    rsp_id_d    = cur_id_q;
                end else if (cnt_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    rsp_id_d    = cur_id_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_id_d = cur_id_q;
            end
            default: ;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = (state_q != ST_IDLE);
    assign eng_start     = eng_start_q;
    assign eng_base      = base_q;
    assign eng_exp       = exp_q;

endmodule
